// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor
// ------------------
// Sits between the eviction write buffer and physical memory. It turns one
// 256-bit cacheline read or write request into a 4-beat, 64-bit burst on the
// memory port, and then returns a single-cycle completion pulse upstream.
//
// Ports
//   clk        clock
//   rst        asynchronous, active-high reset
//   line_i     write line from the upstream buffer
//   line_o     assembled read line to the upstream buffer
//   address_i  line address from upstream
//   read_i     line read request, held until resp_o
//   write_i    line write request, held until resp_o (wins over read_i)
//   resp_o     one-cycle completion pulse to upstream
//   burst_i    read beat data from memory
//   burst_o    write beat data to memory
//   address_o  line-aligned address to memory, stable for the whole burst
//   read_o     burst read request
//   write_o    burst write request
//   resp_i     per-beat acknowledge from memory
//
// All outputs come straight from flops. Each output flop is loaded from the
// next-state value, so read_o/write_o/resp_o still behave as Moore outputs of
// the state they belong to, with no extra latency.
module line_burst_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int BEATS       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [31:0]            address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [31:0]            address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_BURST = 3'd1,
    RD_DONE  = 3'd2,
    WR_BURST = 3'd3,
    WR_DONE  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [31:0]            addr_q, addr_d;
  logic [LINE_WIDTH-1:0]  wbuf_q, wbuf_d;
  logic [LINE_WIDTH-1:0]  line_q, line_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic                   read_q, read_d;
  logic                   write_q, write_d;
  logic                   resp_q, resp_d;

  // Next-state, datapath and next-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    line_d  = line_q;
    burst_d = burst_q;
    read_d  = 1'b0;
    write_d = 1'b0;
    resp_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // resp_i is deliberately ignored here so stray acks cannot start anything.
        if (write_i) begin
          wbuf_d  = line_i;
          addr_d  = {address_i[31:5], 5'b00000};
          cnt_d   = 2'd0;
          state_d = WR_BURST;
        end else if (read_i) begin
          addr_d  = {address_i[31:5], 5'b00000};
          cnt_d   = 2'd0;
          state_d = RD_BURST;
        end else begin
          state_d = IDLE;
        end
      end

      RD_BURST: begin
        if (resp_i) begin
          // Beat n lands in bits [64n+63:64n]; untouched beats keep old data.
          for (int b = 0; b < BEATS; b++) begin
            if (cnt_q == 2'(b)) begin
              line_d[b*BURST_WIDTH +: BURST_WIDTH] = burst_i;
            end else begin
              line_d[b*BURST_WIDTH +: BURST_WIDTH] = line_q[b*BURST_WIDTH +: BURST_WIDTH];
            end
          end
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = RD_DONE;
          end else begin
            state_d = RD_BURST;
          end
        end else begin
          state_d = RD_BURST;
        end
      end

      RD_DONE: begin
        state_d = IDLE;
      end

      WR_BURST: begin
        if (resp_i) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = WR_DONE;
          end else begin
            state_d = WR_BURST;
          end
        end else begin
          state_d = WR_BURST;
        end
      end

      WR_DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase

    read_d  = (state_d == RD_BURST);
    write_d = (state_d == WR_BURST);
    resp_d  = (state_d == RD_DONE) || (state_d == WR_DONE);

    // burst_o presents the beat the counter will point at next cycle; it
    // simply holds its last value outside a write burst.
    if (state_d == WR_BURST) begin
      for (int b = 0; b < BEATS; b++) begin
        if (cnt_d == 2'(b)) begin
          burst_d = wbuf_d[b*BURST_WIDTH +: BURST_WIDTH];
        end else begin
          burst_d = burst_d;
        end
      end
    end else begin
      burst_d = burst_q;
    end
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= 32'd0;
      wbuf_q  <= {LINE_WIDTH{1'b0}};
      line_q  <= {LINE_WIDTH{1'b0}};
      burst_q <= {BURST_WIDTH{1'b0}};
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      line_q  <= line_d;
      burst_q <= burst_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
    end
  end

  assign line_o    = line_q;
  assign burst_o   = burst_q;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Self-checking bench for line_burst_adaptor. The bench plays both the
// upstream buffer and the memory; its reference model is transaction level:
// the expected line is the previous line with each acknowledged read beat
// written into its slot, the expected write beat is the latched line sliced
// by the number of acks seen so far, and resp_o is due exactly one cycle
// after the 4th ack.
module tb_line_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  int n_tests = 0;
  int n_fail  = 0;

  logic [255:0] exp_line;
  logic [31:0]  exp_addr;

  line_burst_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Idle cycles; optionally with random stray acks that must be ignored.
  task automatic idle_cycles(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("idle_read_o", read_o, 1'b0);
      check_eq("idle_write_o", write_o, 1'b0);
      check_eq("idle_resp_o", resp_o, 1'b0);
      check_eq("idle_line_o", line_o, exp_line);
      check_eq("idle_addr_o", address_o, exp_addr);
      read_i  = 1'b0;
      write_i = 1'b0;
      resp_i  = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      burst_i = {$urandom, $urandom};
    end
  endtask

  // One line transaction. data = line to write, or the beats memory returns.
  // gap < 0 gives random wait states of 0..2 before each ack.
  // abort_at >= 0 pulses rst once that many beats have been acknowledged.
  task automatic txn(input bit wr, input bit also_rd, input logic [31:0] addr,
                     input logic [255:0] data, input int gap, input int abort_at);
    int acks;
    int waitc;
    int cyc;
    logic [31:0] ea;
    @(negedge clk);
    check_eq("req_idle_read_o", read_o, 1'b0);
    check_eq("req_idle_write_o", write_o, 1'b0);
    check_eq("req_idle_resp_o", resp_o, 1'b0);
    check_eq("req_idle_line_o", line_o, exp_line);
    read_i    = (!wr) || also_rd;
    write_i   = wr;
    address_i = addr;
    line_i    = wr ? data : {8{$urandom}};
    resp_i    = 1'($urandom_range(0, 1));
    burst_i   = {$urandom, $urandom};
    ea        = {addr[31:5], 5'b00000};
    exp_addr  = ea;
    acks      = 0;
    cyc       = 0;
    waitc     = (gap < 0) ? $urandom_range(0, 2) : gap;
    while (acks < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      check_eq("busy_read_o", read_o, !wr);
      check_eq("busy_write_o", write_o, wr);
      check_eq("busy_resp_o", resp_o, 1'b0);
      check_eq("busy_addr_o", address_o, ea);
      check_eq("busy_line_o", line_o, exp_line);
      if (wr) begin
        check_eq("wr_burst_o", burst_o, data[64*acks +: 64]);
      end
      if (acks == abort_at) begin
        rst = 1'b1;
        #1;
        exp_line = '0;
        exp_addr = '0;
        check_eq("rst_read_o", read_o, 1'b0);
        check_eq("rst_write_o", write_o, 1'b0);
        check_eq("rst_resp_o", resp_o, 1'b0);
        check_eq("rst_line_o", line_o, exp_line);
        check_eq("rst_addr_o", address_o, exp_addr);
        read_i  = 1'b0;
        write_i = 1'b0;
        resp_i  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      // Mid-burst changes to upstream inputs must be ignored.
      address_i = $urandom;
      line_i    = {8{$urandom}};
      if (waitc == 0) begin
        resp_i  = 1'b1;
        burst_i = data[64*acks +: 64];
        if (!wr) exp_line[64*acks +: 64] = data[64*acks +: 64];
        acks++;
        waitc = (gap < 0) ? $urandom_range(0, 2) : gap;
      end else begin
        resp_i  = 1'b0;
        burst_i = {$urandom, $urandom};
        waitc--;
      end
    end
    check_eq("ack_budget", 32'(acks), 32'd4);
    @(negedge clk);
    check_eq("done_resp_o", resp_o, 1'b1);
    check_eq("done_read_o", read_o, 1'b0);
    check_eq("done_write_o", write_o, 1'b0);
    check_eq("done_line_o", line_o, exp_line);
    check_eq("done_addr_o", address_o, ea);
    // Stray ack in the DONE state, and the request is dropped.
    resp_i  = 1'($urandom_range(0, 1));
    burst_i = {$urandom, $urandom};
    write_i = 1'b0;
    read_i  = also_rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] d;
    rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    exp_line = '0;
    exp_addr = '0;
    #12;
    check_eq("reset_read_o", read_o, 1'b0);
    check_eq("reset_write_o", write_o, 1'b0);
    check_eq("reset_resp_o", resp_o, 1'b0);
    check_eq("reset_line_o", line_o, 256'd0);
    check_eq("reset_burst_o", burst_o, 64'd0);
    check_eq("reset_addr_o", address_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Read, zero wait, known beats; address 0x1234 aligns to 0x1220.
    txn(1'b0, 1'b0, 32'h0000_1234,
        {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, -1);
    check_eq("dir_read_addr", exp_addr, 32'h0000_1220);
    // Stray acks in IDLE.
    idle_cycles(3, 1'b1);

    // Write with 2-cycle gaps between acks; read_o must stay low.
    txn(1'b1, 1'b0, 32'hDEAD_BEEF,
        256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0, 2, -1);
    idle_cycles(1, 1'b0);

    // Simultaneous read and write: write first, then the held read runs.
    txn(1'b1, 1'b1, 32'h0000_8040, {8{32'hA5A5_0F0F}}, -1, -1);
    txn(1'b0, 1'b0, 32'h0000_8040, {$urandom, $urandom, $urandom, $urandom,
                                    $urandom, $urandom, $urandom, $urandom}, -1, -1);

    // Back-to-back read then write; line_o must keep the read data.
    txn(1'b0, 1'b0, 32'h1000_0000, {8{$urandom}}, 1, -1);
    txn(1'b1, 1'b0, 32'h2000_0020, {8{$urandom}}, 0, -1);
    idle_cycles(1, 1'b0);

    // Reset after beat 2 of a read, then a normal read.
    txn(1'b0, 1'b0, 32'h0000_4444, {8{$urandom}}, -1, 2);
    txn(1'b0, 1'b0, 32'h0000_5555, {8{$urandom}}, -1, -1);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        txn(1'b1, 1'b1, $urandom, d, -1, -1);
        txn(1'b0, 1'b0, $urandom, {8{$urandom}}, -1, -1);
      end else begin
        txn(1'($urandom_range(0, 1)), 1'b0, $urandom, d, -1, -1);
      end
      idle_cycles($urandom_range(0, 2), 1'b1);
    end

    idle_cycles(2, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
